// File: rtl/sum_array_pkg.sv
// Shared definitions for the array fill/sum blocks: default widths and FSM state encoding.
package sum_array_pkg;
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_FINISH = 2'd2
  } state_e;
endpackage

// File: rtl/array_writer.sv
// Streams len words from a valid/ready source into consecutive BRAM addresses
// starting at base (wrapping), keeping a running checksum of the words written.
module array_writer
  import sum_array_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W:0]     len,
  input  logic [ADDR_W-1:0]   base,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_di,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum
);

  state_e            state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] base_q;
  logic              xfer;

  assign in_ready = (state == S_WRITE) && (cnt < len_q);
  assign xfer     = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      cnt       <= '0;
      base_q    <= '0;
      bram_en   <= 1'b0;
      bram_we   <= '0;
      bram_addr <= '0;
      bram_di   <= '0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      bram_en <= xfer;
      bram_we <= {(DATA_W/8){xfer}};
      done    <= 1'b0;
      if (xfer) begin
        bram_addr <= base_q + cnt[ADDR_W-1:0];
        bram_di   <= in_data;
        checksum  <= checksum + in_data;
        cnt       <= cnt + 1'b1;
      end
      case (state)
        S_IDLE: if (start) begin
          len_q    <= len;
          base_q   <= base;
          cnt      <= '0;
          checksum <= '0;
          if (len == '0) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end else begin
            state <= S_WRITE;
          end
        end
        // Leave one cycle after the final accept so done trails the last strobe.
        S_WRITE: if (cnt == len_q) begin
          state <= S_FINISH;
          done  <= 1'b1;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_writer.sv
// Bench for array_writer: table of directed fills, random fills against a
// word-list model, plus reset-mid-fill and idle-input sequences.
module tb_array_writer;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   len;
  logic [AW-1:0] base;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_di;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  int total = 0;
  int bad   = 0;

  array_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .base(base),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_di(bram_di), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          b;
    int          l;
    int          pat;      // 0 back-to-back, 1 valid every other cycle, 2 random valid
    logic [31:0] ws;       // words are ws, ws+1, ...
    int          restart;  // cycle of a stray start pulse while busy, -1 none
    int          efirst;
    int          elast;
    logic [31:0] esum;
  } vec_t;

  vec_t tbl[8];

  // Drive one fill and check every strobe against the expected word list.
  task automatic run_fill(input int b, input int l, input int pat, input logic [31:0] ws,
                          input bit rndw, input int restart,
                          output int fa, output int la, output logic [31:0] dsum);
    logic [31:0] words[$];
    logic [31:0] esum;
    int idx, nwr, nd, done_cyc, last_strobe, seq_err;
    bit xfer_prev;
    words = {};
    esum  = 0;
    for (int i = 0; i < l; i++) begin
      words.push_back(rndw ? $urandom : ws + i);
      esum += words[i];
    end
    @(negedge clk);
    start = 1'b1; len = l[AW:0]; base = b[AW-1:0]; in_valid = 1'b0;
    idx = 0; nwr = 0; nd = 0; done_cyc = -1; last_strobe = -1; seq_err = 0;
    xfer_prev = 1'b0; fa = -1; la = -1; dsum = '0;
    for (int cyc = 1; cyc < 1200 && nd == 0; cyc++) begin
      @(negedge clk);
      start = (cyc == restart);
      if (cyc == restart) begin len = 5; base = 200; end
      if (bram_en !== xfer_prev) seq_err++;
      if (bram_en) begin
        if (nwr >= l) seq_err++;
        else if (bram_addr !== AW'((b + nwr) % 512) || bram_di !== words[nwr] || bram_we !== 4'hF)
          seq_err++;
        if (nwr == 0) fa = int'(bram_addr);
        la = int'(bram_addr);
        nwr++;
        last_strobe = cyc;
      end
      if (done) begin nd++; done_cyc = cyc; dsum = checksum; end
      case (pat)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2) == 1;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data   = (idx < l) ? words[idx] : $urandom;
      xfer_prev = in_valid && in_ready;
      if (xfer_prev) idx++;
    end
    chk("writes", 64'(nwr), 64'(l));
    chk("strobe_seq", 64'(seq_err), 64'd0);
    chk("done_cnt", 64'(nd), 64'd1);
    chk("done_time", 64'(done_cyc), 64'(l == 0 ? 1 : last_strobe + 1));
    chk("sum_at_done", 64'(dsum), 64'(esum));
    @(negedge clk);
    chk("done_once", {63'd0, done}, 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sum_hold", 64'(checksum), 64'(esum));
  endtask

  initial begin
    int fa, la, tr;
    logic [31:0] ds;
    tbl[0] = '{0,   10,  0, 32'd1,          -1, 0,   9,   32'd55};
    tbl[1] = '{0,   10,  1, 32'd1,          -1, 0,   9,   32'd55};
    tbl[2] = '{510, 4,   0, 32'd10,         -1, 510, 1,   32'd46};
    tbl[3] = '{0,   0,   0, 32'd1,          -1, -1,  -1,  32'd0};
    tbl[4] = '{40,  8,   0, 32'd1,           3, 40,  47,  32'd36};
    tbl[5] = '{511, 2,   1, 32'hFFFF_FFFF,  -1, 511, 0,   32'hFFFF_FFFF};
    tbl[6] = '{300, 512, 0, 32'd1,          -1, 300, 299, 32'd131328};
    tbl[7] = '{100, 1,   2, 32'd7,          -1, 100, 100, 32'd7};

    reset = 1'b0; start = 1'b0; len = '0; base = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {59'd0, in_ready, bram_en, bram_we, busy, done}, 64'd0);
    chk("rst_addr", 64'(bram_addr), 64'd0);
    chk("rst_di", 64'(bram_di), 64'd0);
    chk("rst_sum", 64'(checksum), 64'd0);
    reset = 1'b1;

    // Valid data while idle must not reach the BRAM.
    in_valid = 1'b1; in_data = 32'hDEAD;
    tr = 0;
    repeat (4) begin
      @(negedge clk);
      if (bram_en || in_ready || busy) tr++;
    end
    chk("idle_ignore", 64'(tr), 64'd0);
    in_valid = 1'b0;

    // Reset after three of eight words.
    @(negedge clk);
    start = 1'b1; len = 8; base = 20;
    @(negedge clk);
    start = 1'b0;
    tr = 0;
    for (int c = 0; c < 20 && tr < 3; c++) begin
      in_valid = 1'b1; in_data = 32'(100 + tr);
      if (in_ready) tr++;
      if (tr < 3) @(negedge clk);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ctl", {59'd0, in_ready, bram_en, bram_we, busy, done}, 64'd0);
    chk("midrst_addr", 64'(bram_addr), 64'd0);
    chk("midrst_sum", 64'(checksum), 64'd0);
    tr = 0;
    repeat (3) begin
      @(negedge clk);
      if (bram_en || done || busy) tr++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bram_en || done || busy) tr++;
    end
    chk("midrst_quiet", 64'(tr), 64'd0);
    in_valid = 1'b0;

    foreach (tbl[i]) begin
      run_fill(tbl[i].b, tbl[i].l, tbl[i].pat, tbl[i].ws, 1'b0, tbl[i].restart, fa, la, ds);
      chk($sformatf("tbl%0d_first", i), 64'(fa), 64'(tbl[i].efirst));
      chk($sformatf("tbl%0d_last", i), 64'(la), 64'(tbl[i].elast));
      chk($sformatf("tbl%0d_sum", i), 64'(ds), 64'(tbl[i].esum));
    end

    for (int r = 0; r < 8; r++)
      run_fill(int'($urandom_range(0, 511)), int'($urandom_range(0, 40)), 2, 32'd0, 1'b1, -1, fa, la, ds);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/array_writer.md
ARRAY_WRITER -- requirements
Module: array_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning BRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning BRAM data width.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a fill; sampled only in IDLE.
REQ-006 SHALL have port len  input  ADDR_W+1  word count to write, 0..2^ADDR_W, captured on start.
REQ-007 SHALL have port base  input  ADDR_W  first BRAM address, captured on start.
REQ-008 SHALL have port in_valid  input  1  source has a word on in_data.
REQ-009 SHALL have port in_data  input  DATA_W  word to write.
REQ-010 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-011 SHALL have port bram_en  output  1  BRAM enable.
REQ-012 SHALL have port bram_we  output  DATA_W/8  BRAM byte write enables.
REQ-013 SHALL have port bram_addr  output  ADDR_W  BRAM address.
REQ-014 SHALL have port bram_di  output  DATA_W  BRAM write data.
REQ-015 SHALL have port busy  output  1  fill in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at fill completion.
REQ-017 SHALL have port checksum  output  DATA_W  sum of words written in current/last fill.

Function
REQ-018 SHALL implement states IDLE, WRITE, FINISH.
REQ-019 IDLE: start=1 and len>0 -> WRITE, capturing len, base, clearing word counter and checksum.
REQ-020 IDLE: start=1 and len=0 -> FINISH, checksum cleared, no BRAM write.
REQ-021 in_ready SHALL be 1 only in WRITE while accepted count < captured len.
REQ-022 Transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; in_valid in IDLE/FINISH is ignored.
REQ-023 Transfer at cycle k SHALL produce, at cycle k+1 (registered), bram_en=1, bram_we=all ones, bram_addr=(base+index) mod 2^ADDR_W, bram_di=word.
REQ-024 With no transfer at cycle k, bram_en and bram_we SHALL be 0 at k+1; bram_addr/bram_di hold.
REQ-025 checksum SHALL add each accepted word modulo 2^DATA_W, updated in the same cycle as its write strobe.
REQ-026 Accepting the final word SHALL move WRITE -> FINISH; in_ready is 0 the following cycle.
REQ-027 FINISH SHALL last exactly one cycle with done=1, then return to IDLE; done aligns with last write strobe +1 cycle.
REQ-028 busy SHALL be 1 in WRITE and FINISH, 0 in IDLE.
REQ-029 start asserted while busy SHALL be ignored; captured len/base unchanged.
REQ-030 Address SHALL wrap from 2^ADDR_W-1 to 0 without error.
REQ-031 checksum SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, in_ready=0, bram_en=0, bram_we=0, bram_addr=0, bram_di=0, busy=0, done=0, checksum=0, counters 0.
REQ-033 Reset mid-fill SHALL abandon the fill with no further writes and no done pulse.

Structure
REQ-034 A shared package sum_array_pkg SHALL hold ADDR_W/DATA_W defaults and the state encoding, shared with sum_of_array.
REQ-035 Single module, no sub-module; counter, checksum and FSM in one file.

Verification
REQ-036 base=0, len=10, words 1..10 back-to-back -> writes addr 0..9 on consecutive cycles, checksum=55, one done pulse.
REQ-037 Same fill with in_valid low every other cycle -> strobes only after transfers, same addresses, checksum=55.
REQ-038 base=510, len=4, words A..D -> addresses 510,511,0,1; done after fourth strobe.
REQ-039 len=0 start -> no bram_en, done one cycle after start, checksum=0.
REQ-040 reset=0 after 3 of 8 words -> strobes stop at once, all outputs 0, no done; new start works normally.
REQ-041 start pulsed with len=5 during len=8 fill -> ignored, exactly 8 writes, single done.
